// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter that lets four requesters perform READ/WRITE/CLEAR/PRESET
// operations on eight shared registers through a single strobe/data bus.
module register_bus_arbiter #(
  parameter int NrOfBits = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic [3:0]            req,
  input  logic [7:0]            req_op,
  input  logic [11:0]           req_addr,
  input  logic [4*NrOfBits-1:0] req_data,
  output logic [3:0]            gnt,
  output logic [3:0]            done,
  output logic [7:0]            reg_ce,
  output logic [7:0]            reg_cs,
  output logic [7:0]            reg_clr,
  output logic [7:0]            reg_pre,
  output logic [NrOfBits-1:0]   bus_d,
  output logic                  rd_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01,
                            OP_CLEAR = 2'b10, OP_PRESET = 2'b11} op_e;

  state_e                state_q, state_d;
  logic   [1:0]          ptr_q, ptr_d;
  logic   [1:0]          win_q, win_d;
  op_e                   op_q, op_d;
  logic   [2:0]          addr_q, addr_d;
  logic   [NrOfBits-1:0] data_q, data_d;

  logic                  pick_found;
  logic   [1:0]          pick_idx;
  logic   [1:0]          pick_op;
  logic   [2:0]          pick_addr;
  logic   [NrOfBits-1:0] pick_data;

  // Scan from ptr upward modulo 4; the first asserted request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_op    = '0;
    pick_addr  = '0;
    pick_data  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % 4;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(idx);
        pick_op    = req_op[2*idx +: 2];
        pick_addr  = req_addr[3*idx +: 3];
        pick_data  = req_data[NrOfBits*idx +: NrOfBits];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (Tick) begin
      unique case (state_q)
        IDLE: if (pick_found) begin
          state_d = EXEC;
          win_d   = pick_idx;
          op_d    = op_e'(pick_op);
          addr_d  = pick_addr;
          data_d  = pick_data;
        end
        EXEC: state_d = DONE;
        DONE: begin
          state_d = IDLE;
          ptr_d   = win_q + 2'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs depend only on state and latched fields, so a Tick=0 stall holds them.
  always_comb begin
    gnt      = '0;
    done     = '0;
    reg_ce   = '0;
    reg_cs   = '1;
    reg_clr  = '0;
    reg_pre  = '0;
    bus_d    = '0;
    rd_valid = 1'b0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      EXEC: begin
        gnt[win_q] = 1'b1;
        unique case (op_q)
          OP_READ: begin
            reg_cs[addr_q] = 1'b0;
            rd_valid       = 1'b1;
          end
          OP_WRITE: begin
            reg_ce[addr_q] = 1'b1;
            bus_d          = data_q;
          end
          OP_CLEAR:  reg_clr[addr_q] = 1'b1;
          OP_PRESET: reg_pre[addr_q] = 1'b1;
          default: ;
        endcase
      end
      DONE:    done[win_q] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Bench for register_bus_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_register_bus_arbiter;

  localparam int NB = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Tick  = 1'b1;
  logic [3:0]    req   = '0;
  logic [7:0]    req_op = '0;
  logic [11:0]   req_addr = '0;
  logic [4*NB-1:0] req_data = '0;
  logic [3:0]    gnt, done;
  logic [7:0]    reg_ce, reg_cs, reg_clr, reg_pre;
  logic [NB-1:0] bus_d;
  logic          rd_valid, busy;

  int tests = 0;
  int fails = 0;

  register_bus_arbiter #(.NrOfBits(NB)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt), .done(done),
    .reg_ce(reg_ce), .reg_cs(reg_cs), .reg_clr(reg_clr), .reg_pre(reg_pre),
    .bus_d(bus_d), .rd_valid(rd_valid), .busy(busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // One clock edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; req = '0; Tick = 1'b1;
    cyc();
    Reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [2:0] addr,
                         input logic [NB-1:0] data);
    req_op[2*i +: 2]    = op;
    req_addr[3*i +: 3]  = addr;
    req_data[NB*i +: NB] = data;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Tick = 1'b0; req = 4'hF;
    cyc(); cyc();
    tests++;
    if ({gnt, done, reg_ce, reg_cs, reg_clr, reg_pre, bus_d, rd_valid, busy} !==
        {4'h0, 4'h0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_defaults: got gnt=%h done=%h ce=%h cs=%h clr=%h pre=%h bus=%h rv=%b busy=%b",
               gnt, done, reg_ce, reg_cs, reg_clr, reg_pre, bus_d, rd_valid, busy);
    end
    Reset = 1'b0; req = '0; Tick = 1'b1;
  endtask

  task automatic test_write();
    do_reset();
    set_req(0, 2'b01, 3'd3, 8'h5A);
    req = 4'b0001;
    cyc();
    tests++;
    if ({gnt, reg_ce, bus_d, busy} !== {4'b0001, 8'h08, 8'h5A, 1'b1}) begin
      fails++;
      $display("FAIL write_exec: got gnt=%b ce=%h bus=%h busy=%b, want 0001 08 5a 1", gnt, reg_ce, bus_d, busy);
    end
    req = '0; set_req(0, 2'b10, 3'd0, 8'h00);
    cyc();
    tests++;
    if ({done, gnt, reg_ce, bus_d} !== {4'b0001, 4'b0000, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL write_done: got done=%b gnt=%b ce=%h bus=%h, want 0001 0000 00 00", done, gnt, reg_ce, bus_d);
    end
    cyc();
    tests++;
    if ({done, busy} !== {4'b0000, 1'b0}) begin
      fails++;
      $display("FAIL write_idle: got done=%b busy=%b, want 0000 0", done, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_cs;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 3'(2*i + 1), 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g  = 4'b0001 << (k % 4);
      exp_cs = ~(8'h01 << (2*(k % 4) + 1));
      cyc();
      tests++;
      if ({gnt, reg_cs, rd_valid, reg_ce} !== {exp_g, exp_cs, 1'b1, 8'h00}) begin
        fails++;
        $display("FAIL rr_grant_%0d: got gnt=%b cs=%h rv=%b ce=%h, want gnt=%b cs=%h rv=1 ce=00",
                 k, gnt, reg_cs, rd_valid, reg_ce, exp_g, exp_cs);
      end
      cyc();
      tests++;
      if ({done, reg_cs, rd_valid} !== {exp_g, 8'hFF, 1'b0}) begin
        fails++;
        $display("FAIL rr_done_%0d: got done=%b cs=%h rv=%b, want done=%b cs=ff rv=0",
                 k, done, reg_cs, rd_valid, exp_g);
      end
      cyc();
    end
    req = '0;
  endtask

  task automatic test_preset_clear();
    do_reset();
    set_req(2, 2'b11, 3'd7, 8'h00);
    req = 4'b0100;
    cyc();
    // Changing op in flight must not affect the current operation.
    set_req(2, 2'b10, 3'd7, 8'h00);
    tests++;
    if ({gnt, reg_pre, reg_clr} !== {4'b0100, 8'h80, 8'h00}) begin
      fails++;
      $display("FAIL preset_exec: got gnt=%b pre=%h clr=%h, want 0100 80 00", gnt, reg_pre, reg_clr);
    end
    cyc();
    tests++;
    if ({done, reg_pre, reg_clr} !== {4'b0100, 8'h00, 8'h00}) begin
      fails++;
      $display("FAIL preset_done: got done=%b pre=%h clr=%h, want 0100 00 00", done, reg_pre, reg_clr);
    end
    cyc(); cyc();
    tests++;
    if ({gnt, reg_clr, reg_pre} !== {4'b0100, 8'h80, 8'h00}) begin
      fails++;
      $display("FAIL clear_exec: got gnt=%b clr=%h pre=%h, want 0100 80 00", gnt, reg_clr, reg_pre);
    end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_tick_stall();
    do_reset();
    Tick = 1'b0;
    set_req(1, 2'b01, 3'd5, 8'hA5);
    req = 4'b0010;
    cyc();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_idle: got busy=%b, want 0", busy);
    end
    Tick = 1'b1;
    cyc();
    Tick = 1'b0;
    set_req(1, 2'b00, 3'd0, 8'h11);
    req = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      cyc();
      tests++;
      if ({gnt, reg_ce, bus_d, done} !== {4'b0010, 8'h20, 8'hA5, 4'b0000}) begin
        fails++;
        $display("FAIL stall_hold_%0d: got gnt=%b ce=%h bus=%h done=%b, want 0010 20 a5 0000",
                 s, gnt, reg_ce, bus_d, done);
      end
    end
    Tick = 1'b1;
    cyc();
    tests++;
    if ({done, gnt, reg_ce} !== {4'b0010, 4'b0000, 8'h00}) begin
      fails++;
      $display("FAIL stall_done: got done=%b gnt=%b ce=%h, want 0010 0000 00", done, gnt, reg_ce);
    end
    cyc();
  endtask

  task automatic test_reset_abort();
    do_reset();
    set_req(3, 2'b00, 3'd2, 8'h00);
    set_req(0, 2'b11, 3'd1, 8'h00);
    req = 4'b1000;
    cyc();
    tests++;
    if ({gnt, reg_cs} !== {4'b1000, 8'hFB}) begin
      fails++;
      $display("FAIL abort_exec: got gnt=%b cs=%h, want 1000 fb", gnt, reg_cs);
    end
    Reset = 1'b1; Tick = 1'b0;
    cyc();
    Reset = 1'b0; Tick = 1'b1; req = 4'b1001;
    tests++;
    if ({gnt, done, reg_cs, rd_valid, busy} !== {4'h0, 4'h0, 8'hFF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_defaults: got gnt=%b done=%b cs=%h rv=%b busy=%b, want 0 0 ff 0 0",
               gnt, done, reg_cs, rd_valid, busy);
    end
    cyc();
    tests++;
    if ({gnt, reg_pre, done} !== {4'b0001, 8'h02, 4'h0}) begin
      fails++;
      $display("FAIL abort_regrant: got gnt=%b pre=%h done=%b, want 0001 02 0000", gnt, reg_pre, done);
    end
    req = '0;
    cyc(); cyc();
  endtask

  // Reference model: phase 0=waiting, 1=operation on the bus, 2=completion.
  task automatic test_random();
    int          m_phase, m_ptr, m_win, m_op, m_addr;
    logic [NB-1:0] m_data;
    logic [3:0]  e_gnt, e_done;
    logic [7:0]  e_ce, e_cs, e_clr, e_pre;
    logic [NB-1:0] e_bus;
    logic        e_rv, e_busy;
    Reset = 1'b1; Tick = 1'b1; req = '0;
    cyc();
    m_phase = 0; m_ptr = 0; m_win = 0; m_op = 0; m_addr = 0; m_data = '0;
    for (int n = 0; n < 600; n++) begin
      Reset    = ($urandom_range(0, 79) == 0);
      Tick     = ($urandom_range(0, 3) != 0);
      req      = 4'($urandom);
      req_op   = 8'($urandom);
      req_addr = 12'($urandom);
      req_data = 32'($urandom);
      if (Reset) begin
        m_phase = 0; m_ptr = 0;
      end else if (Tick) begin
        if (m_phase == 0) begin
          for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (m_phase == 0 && req[j]) begin
              m_phase = 1; m_win = j;
              m_op = int'(req_op[2*j +: 2]);
              m_addr = int'(req_addr[3*j +: 3]);
              m_data = req_data[NB*j +: NB];
            end
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else begin
          m_phase = 0; m_ptr = (m_win + 1) % 4;
        end
      end
      cyc();
      e_gnt  = (m_phase == 1) ? 4'(1 << m_win) : 4'h0;
      e_done = (m_phase == 2) ? 4'(1 << m_win) : 4'h0;
      e_ce   = (m_phase == 1 && m_op == 1) ? 8'(1 << m_addr) : 8'h00;
      e_cs   = (m_phase == 1 && m_op == 0) ? ~8'(1 << m_addr) : 8'hFF;
      e_clr  = (m_phase == 1 && m_op == 2) ? 8'(1 << m_addr) : 8'h00;
      e_pre  = (m_phase == 1 && m_op == 3) ? 8'(1 << m_addr) : 8'h00;
      e_bus  = (m_phase == 1 && m_op == 1) ? m_data : '0;
      e_rv   = (m_phase == 1 && m_op == 0);
      e_busy = (m_phase != 0);
      tests++;
      if ({gnt, done} !== {e_gnt, e_done}) begin
        fails++;
        $display("FAIL rand_gnt_done cyc %0d: got gnt=%b done=%b, want gnt=%b done=%b",
                 n, gnt, done, e_gnt, e_done);
      end
      tests++;
      if ({reg_ce, reg_cs, reg_clr, reg_pre} !== {e_ce, e_cs, e_clr, e_pre}) begin
        fails++;
        $display("FAIL rand_strobes cyc %0d: got ce=%h cs=%h clr=%h pre=%h, want ce=%h cs=%h clr=%h pre=%h",
                 n, reg_ce, reg_cs, reg_clr, reg_pre, e_ce, e_cs, e_clr, e_pre);
      end
      tests++;
      if ({bus_d, rd_valid, busy} !== {e_bus, e_rv, e_busy}) begin
        fails++;
        $display("FAIL rand_bus cyc %0d: got bus=%h rv=%b busy=%b, want bus=%h rv=%b busy=%b",
                 n, bus_d, rd_valid, busy, e_bus, e_rv, e_busy);
      end
    end
    Reset = 1'b0; req = '0; Tick = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_round_robin();
    test_preset_clear();
    test_tick_stall();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
